// File: rtl/count_date.sv
// rtl/count_date.sv - BCD day/month/year calendar stage with leap years, manual set and century carry.
module count_date #(
  parameter int DIGIT_W     = 4,
  parameter int DAY_TEN_W   = 2,
  parameter int MONTH_TEN_W = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_d,
  input  logic                   up,
  input  logic                   down,
  input  logic [1:0]             sel,
  output logic [DIGIT_W-1:0]     day_unit,
  output logic [DAY_TEN_W-1:0]   day_ten,
  output logic [DIGIT_W-1:0]     month_unit,
  output logic [MONTH_TEN_W-1:0] month_ten,
  output logic [DIGIT_W-1:0]     year_unit,
  output logic [DIGIT_W-1:0]     year_ten,
  output logic                   pulse_c
);

  typedef logic [6:0] v7_t;

  logic [DIGIT_W-1:0]     day_unit_q, day_unit_d, month_unit_q, month_unit_d;
  logic [DIGIT_W-1:0]     year_unit_q, year_unit_d, year_ten_q, year_ten_d;
  logic [DAY_TEN_W-1:0]   day_ten_q, day_ten_d;
  logic [MONTH_TEN_W-1:0] month_ten_q, month_ten_d;

  v7_t  day_b, month_b, year_b, dim_cur, dim_new;
  v7_t  day_n, month_n, year_n, yt_n, yu_n, day_t, day_u, mon_t, mon_u;
  logic leap_cur, leap_n, inc, dec;

  function automatic logic is_leap(input logic [DIGIT_W-1:0] ten, input logic [DIGIT_W-1:0] unit);
    if (!ten[0]) return (unit == DIGIT_W'(0)) || (unit == DIGIT_W'(4)) || (unit == DIGIT_W'(8));
    else         return (unit == DIGIT_W'(2)) || (unit == DIGIT_W'(6));
  endfunction

  function automatic v7_t dim_f(input v7_t month, input logic leap);
    case (month)
      7'd2:                    return leap ? 7'd29 : 7'd28;
      7'd4, 7'd6, 7'd9, 7'd11: return 7'd30;
      default:                 return 7'd31;
    endcase
  endfunction

  // Arithmetic is done on binary copies of the fields; BCD is only the storage format.
  always_comb begin
    day_b    = 7'(day_ten_q) * 7'd10 + 7'(day_unit_q);
    month_b  = 7'(month_ten_q) * 7'd10 + 7'(month_unit_q);
    year_b   = 7'(year_ten_q) * 7'd10 + 7'(year_unit_q);
    leap_cur = is_leap(year_ten_q, year_unit_q);
    dim_cur  = dim_f(month_b, leap_cur);
    inc      = up && !down;
    dec      = down && !up;
    day_n    = day_b;
    month_n  = month_b;
    year_n   = year_b;
    if (en_d) begin
      if (day_b < dim_cur) begin
        day_n = day_b + 7'd1;
      end else begin
        day_n = 7'd1;
        if (month_b < 7'd12) begin
          month_n = month_b + 7'd1;
        end else begin
          month_n = 7'd1;
          year_n  = (year_b == 7'd99) ? 7'd0 : year_b + 7'd1;
        end
      end
    end else begin
      case (sel)
        2'd0: begin
          if (inc)      day_n = (day_b >= dim_cur) ? 7'd1 : day_b + 7'd1;
          else if (dec) day_n = (day_b <= 7'd1) ? dim_cur : day_b - 7'd1;
        end
        2'd1: begin
          if (inc)      month_n = (month_b >= 7'd12) ? 7'd1 : month_b + 7'd1;
          else if (dec) month_n = (month_b <= 7'd1) ? 7'd12 : month_b - 7'd1;
        end
        2'd2: begin
          if (inc)      year_n = (year_b >= 7'd99) ? 7'd0 : year_b + 7'd1;
          else if (dec) year_n = (year_b == 7'd0) ? 7'd99 : year_b - 7'd1;
        end
        default: ;
      endcase
    end
    yt_n    = year_n / 7'd10;
    yu_n    = year_n % 7'd10;
    leap_n  = is_leap(yt_n[DIGIT_W-1:0], yu_n[DIGIT_W-1:0]);
    dim_new = dim_f(month_n, leap_n);
    if (!en_d && (sel == 2'd1 || sel == 2'd2) && day_n > dim_new) day_n = dim_new;
    day_t        = day_n / 7'd10;
    day_u        = day_n % 7'd10;
    mon_t        = month_n / 7'd10;
    mon_u        = month_n % 7'd10;
    day_ten_d    = day_t[DAY_TEN_W-1:0];
    day_unit_d   = day_u[DIGIT_W-1:0];
    month_ten_d  = mon_t[MONTH_TEN_W-1:0];
    month_unit_d = mon_u[DIGIT_W-1:0];
    year_ten_d   = yt_n[DIGIT_W-1:0];
    year_unit_d  = yu_n[DIGIT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day_ten_q    <= '0;
      day_unit_q   <= DIGIT_W'(1);
      month_ten_q  <= '0;
      month_unit_q <= DIGIT_W'(1);
      year_ten_q   <= '0;
      year_unit_q  <= '0;
    end else begin
      day_ten_q    <= day_ten_d;
      day_unit_q   <= day_unit_d;
      month_ten_q  <= month_ten_d;
      month_unit_q <= month_unit_d;
      year_ten_q   <= year_ten_d;
      year_unit_q  <= year_unit_d;
    end
  end

  assign pulse_c    = en_d && (day_b == dim_cur) && (month_b == 7'd12) && (year_b == 7'd99);
  assign day_ten    = day_ten_q;
  assign day_unit   = day_unit_q;
  assign month_ten  = month_ten_q;
  assign month_unit = month_unit_q;
  assign year_ten   = year_ten_q;
  assign year_unit  = year_unit_q;

endmodule

// File: doc/count_date.md
Name: count_date

Overview:
- Calendar stage directly downstream of the hour counter. It consumes the hour stage's one-cycle day-carry strobe (pulse_h), which is driven into en_d.
- Maintains day, month and 2-digit year as BCD digit pairs, with correct month lengths and leap years.
- Provides field-selected manual set via up/down while en_d is low.
- Emits a one-cycle century strobe when the year wraps 99 -> 00.

Parameters:
- DIGIT_W, 4, width of every BCD unit digit and of year_ten.
- DAY_TEN_W, 2, width of day_ten (0..3).
- MONTH_TEN_W, 1, width of month_ten (0..1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- en_d  input  1  day-advance strobe (from hour stage pulse_h); one clk wide
- up  input  1  manual increment of selected field
- down  input  1  manual decrement of selected field
- sel  input  2  field select: 0 = day, 1 = month, 2 = year, 3 = none
- day_unit  output  DIGIT_W  BCD day units
- day_ten  output  DAY_TEN_W  BCD day tens
- month_unit  output  DIGIT_W  BCD month units
- month_ten  output  MONTH_TEN_W  BCD month tens
- year_unit  output  DIGIT_W  BCD year units
- year_ten  output  DIGIT_W  BCD year tens
- pulse_c  output  1  century carry strobe

Behaviour:
- Reset (async, rst_n low): date = 01/01/00, i.e. day_ten=0, day_unit=1, month_ten=0, month_unit=1, year=00. Outputs hold these values while reset is asserted. Reset asserted mid-adjust or mid-rollover gives the same values.
- All digits are registered and update on the clk rising edge. Latency from a qualifying input to the new value is 1 cycle.
- Leap year: year mod 4 == 0, evaluated on BCD digits.
  - Leap if year_ten is even and year_unit is in {0, 4, 8}.
  - Leap if year_ten is odd and year_unit is in {2, 6}.
  - Year 00 is leap.
- dim(month, year), days in month:
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - 29 for month 2 in a leap year, 28 otherwise.
- Priority: en_d > manual adjust. While en_d=1, up/down/sel are ignored.
- Run (en_d=1):
  - If day < dim: day+1, with BCD carry unit 9 -> 0 and ten+1.
  - If day == dim: day=01 and month advances.
  - Month advance: month < 12 gives month+1 (BCD, 09 -> 10). Month 12 gives month=01 and year advances.
  - Year advance: BCD +1. 99 -> 00.
- pulse_c = en_d AND day==dim AND month==12 AND year==99. It is combinational, high exactly in the cycle whose edge performs 31/12/99 -> 01/01/00, and low in all other cycles, including during manual adjust.
- Adjust (en_d=0), acting only on the selected field:
  - up && !down: +1 with wrap. Day 1..dim(current), dim -> 01. Month 12 -> 01. Year 99 -> 00.
  - down && !up: -1 with wrap. Day 01 -> dim(current). Month 01 -> 12. Year 00 -> 99.
  - up && down, neither, or sel==3: hold.
  - Manual adjust never ripples into other fields: a day wrap does not change month, and a month wrap does not change year.
- Day clamp: on a month or year adjust, in the same edge, day = min(day, dim(new month, new year)).
  - Example: 31/03 with month down gives 28/02 or 29/02.
  - Example: 29/02/04 with year up gives 28/02/05.
- The block never produces an illegal BCD digit, day 00, month 00, or day > dim. Adjust is level-sensitive: it steps once per clk while held (debounce/one-shot is upstream).

Test Plan:
- Reset then release, en_d pulsed 31 times -> after each pulse day 02..31 then 01/02/00. pulse_c stays 0 throughout.
- Preload 28/02/01 via adjust, one en_d -> 01/03/01. Preload 28/02/04, one en_d -> 29/02/04, a second en_d -> 01/03/04. Year 00: 28/02/00 -> 29/02/00.
- Preload 31/12/99, one en_d -> 01/01/00, with pulse_c=1 in exactly that cycle and 0 in the next.
- Adjust sel=1 down from 01/01/00 -> 01/12/00. Set 31/01/03, sel=1 up -> 28/02/03 (clamped). sel=2 on 29/02/04 up -> 28/02/05.
- sel=0, down at 01/04/10 -> 30/04/10, month unchanged. up&&down or sel=3 -> no change. en_d=1 together with up=1, sel=2 -> only the day advances, year unchanged.
- Assert rst_n low mid-sequence (e.g. at 15/07/42 during up hold) -> immediately 01/01/00 without a clock edge. pulse_c=0.
